// File: rtl/dpram_port_ctrl.sv
// dpram_port_ctrl: valid/ready request front-end for one port of the byte-enabled dual-port RAM,
// tracking the RAM's 1-cycle read latency and buffering up to two read responses.
module dpram_port_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 7
) (
    input  logic                    clock,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [DATA_WIDTH/8-1:0] req_byteena,
    input  logic [DATA_WIDTH-1:0]   req_wrdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [DATA_WIDTH-1:0]   resp_data,
    output logic [ADDR_WIDTH-1:0]   ram_address,
    output logic [DATA_WIDTH/8-1:0] ram_byteena,
    output logic [DATA_WIDTH-1:0]   ram_wrdata,
    output logic                    ram_wren,
    input  logic [DATA_WIDTH-1:0]   ram_rddata
);
    logic [1:0]            count;
    logic                  inflight, rd_ptr, wr_ptr;
    logic [DATA_WIDTH-1:0] fifo [2];
    logic                  accept, push, pop, unused_bits;
    always_comb begin
        req_ready   = rst_n && (({1'b0, count} + {2'b0, inflight}) < 3'd2);
        accept      = req_valid && req_ready;
        ram_address = req_addr[ADDR_WIDTH+1:2];
        ram_byteena = req_byteena;
        ram_wrdata  = req_wrdata;
        ram_wren    = accept && req_write;
        resp_valid  = (count != 2'd0) || inflight;
        resp_data   = (count != 2'd0) ? fifo[rd_ptr] : ram_rddata;
        // Returning word must queue unless it was handed straight out on the bypass path.
        push        = inflight && ((count != 2'd0) || !resp_ready);
        pop         = resp_ready && (count != 2'd0);
        unused_bits = ^req_addr[1:0];
    end
    always_ff @(posedge clock) begin
        if (!rst_n) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            rd_ptr   <= 1'b0;
            wr_ptr   <= 1'b0;
        end else begin
            inflight <= accept && !req_write;
            count    <= count + {1'b0, push} - {1'b0, pop};
            if (push) begin
                fifo[wr_ptr] <= ram_rddata;
                wr_ptr       <= ~wr_ptr;
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
        end
    end
endmodule

// File: doc/dpram_port_ctrl.md
Name: dpram_port_ctrl

Overview:
- Request/response front-end for one port of the byte-enabled dual-port data RAM.
- Accepts read/write requests from a bus master over valid/ready and drives the RAM port's address/byteena/wrdata/wren.
- Tracks the RAM's fixed 1-cycle registered read latency and returns read data over a back-pressurable valid/ready response channel, with a 2-entry buffer.
- Sits between the CPU data-side load/store unit and port a (or b) of the RAM.

Parameters:
DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes)
ADDR_WIDTH, 7, RAM word-address width; byte address is ADDR_WIDTH+2 bits

Ports:
clock  in  1  single clock; all state changes on posedge
rst_n  in  1  synchronous active-low reset
req_valid  in  1  master presents a request
req_ready  out  1  block accepts request this cycle
req_write  in  1  1 = write, 0 = read
req_addr  in  ADDR_WIDTH+2  byte address; bits [1:0] ignored
req_byteena  in  4  byte lane enables for writes; ignored for reads
req_wrdata  in  32  write data
resp_valid  out  1  read data available
resp_ready  in  1  consumer takes read data
resp_data  out  32  read data
ram_address  out  ADDR_WIDTH  to RAM address port
ram_byteena  out  4  to RAM byteena
ram_wrdata  out  32  to RAM wrdata
ram_wren  out  1  to RAM wren
ram_rddata  in  32  from RAM rddata; registered, valid 1 cycle after address

Behaviour:
- Accept: a request is accepted on a cycle with req_valid && req_ready (cycle T).
- RAM drive is combinational:
  - ram_address = req_addr[ADDR_WIDTH+1:2]
  - ram_byteena = req_byteena
  - ram_wrdata = req_wrdata
  - ram_wren = req_valid && req_ready && req_write
  - While rst_n=0 or not accepted, ram_wren=0.
- Writes: committed by the RAM at the posedge ending T. No response generated.
- Reads: set inflight=1 at the posedge ending T; RAM data appears on ram_rddata during T+1.
- State:
  - inflight (0/1): a read issued last cycle.
  - 2-entry FIFO (count 0..2) of captured read data, with a 1-bit read pointer and a 1-bit write pointer, wrapping.
- Flow control:
  - req_ready = rst_n && (count + inflight < 2), from registers only.
  - Independent of req_write and resp_ready.
- Response mux:
  - count>0: resp_valid=1, resp_data = FIFO head.
  - count==0 && inflight: resp_valid=1, resp_data = ram_rddata (bypass; zero added latency, read data visible in T+1).
  - Otherwise resp_valid=0 and resp_data is don't-care; the bench checks resp_data only when resp_valid=1.
- Capture rules at each posedge:
  - If inflight and the presented word is not consumed (bypass case with resp_ready=0), or count>0 (data queues behind head): push ram_rddata.
  - If resp_valid && resp_ready && count>0: pop.
  - Push and pop in the same cycle: count unchanged; ordering preserved (FIFO order = issue order).
- Throughput: with resp_ready held 1, back-to-back reads sustain 1 per cycle; count stays 0.
- Full: count + inflight == 2 forces req_ready=0, for writes too. Writes stay ordered behind reads, though RAM old-data semantics already guarantee a read returns pre-write data.
- Read-after-write, same address:
  - Write at T, read at T+1 returns the new data.
  - Read and write on the same cycle are impossible (single request).
- Reset (rst_n=0 sampled at posedge):
  - inflight=0, count=0, pointers=0.
  - Next cycle: resp_valid=0, req_ready=0 while rst_n low, ram_wren=0.
  - An in-flight read or buffered data is discarded, never returned.
  - First accept possible on the first cycle with rst_n=1.
- Outputs after reset: resp_valid=0, req_ready=1 (once rst_n=1), ram_wren=0.

Test Plan:
- Write 0xDEADBEEF to byte addr 0x10 (all lanes), then read 0x10 → resp_valid exactly 1 cycle after the read accept, resp_data=0xDEADBEEF.
- Write 0x11223344 to addr 0x20, then write byteena=4'b0101 data 0xAABBCCDD, then read → 0x11BB33DD.
- Reads to 0x00,0x04,0x08,0x0C on consecutive cycles, resp_ready=1 → 4 responses on 4 consecutive cycles in order; req_ready never drops.
- resp_ready=0, issue reads A,B → req_ready drops after the 2nd accept, count=2. Raise resp_ready → data A then B returned; req_ready returns to 1.
- Read issued, rst_n=0 at the next posedge → resp_valid=0 after reset, the in-flight read is not returned, ram_wren=0 during reset, FIFO empty.
- Push/pop same cycle: count=1, resp_ready=1, new read completing → count stays 1, order preserved across 6 interleaved reads with random resp_ready.
